// File: rtl/mul_unit.sv
// mul_unit: iterative unsigned shift-add multiplier with a 2*WIDTH-bit
// multiply-accumulate register. One start cycle in IDLE, WIDTH RUN cycles
// (one multiplier bit per cycle), then a single DONE cycle that strobes the result.
module mul_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_en,
    input  logic             mul_msb,
    input  logic             mul_acc,
    input  logic             mul_rst,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic             wr_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   mcand;       // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier;     // multiplier, shifted right each step
    logic [PW-1:0]   partial;     // running partial product
    logic [PW-1:0]   acc;         // MAC accumulator, survives mul_rst
    logic [CW-1:0]   count;
    logic            msb_q;       // latched mul_msb
    logic            acc_q;       // latched mul_acc (only meaningful with mul_msb)
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;

    logic            start;
    logic            last_step;
    logic [PW-1:0]   partial_nxt;
    logic [PW-1:0]   mac_sum;

    assign start       = (state == IDLE) && mul_en && !mul_rst;
    assign last_step   = (state == RUN) && (count == CW'(WIDTH - 1));
    assign partial_nxt = partial + (mplier[0] ? mcand : '0);
    assign mac_sum     = acc + partial_nxt;

    // Next-state logic; mul_rst forces IDLE from any state.
    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (mul_rst) state_nxt = IDLE;
    end

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: operand capture on start, one shift-add step per RUN cycle,
    // result/accumulator load on the final step; an abort leaves acc and results alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            acc     <= '0;
            count   <= '0;
            msb_q   <= 1'b0;
            acc_q   <= 1'b0;
            res_lo  <= '0;
            res_hi  <= '0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, op_a};
            mplier  <= op_b;
            partial <= '0;
            count   <= '0;
            msb_q   <= mul_msb;
            acc_q   <= mul_msb & mul_acc;
        end else if (state == RUN && !mul_rst) begin
            partial <= partial_nxt;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + CW'(1);
            if (last_step) begin
                if (acc_q) begin
                    acc    <= mac_sum;
                    res_lo <= mac_sum[WIDTH-1:0];
                    res_hi <= mac_sum[PW-1:WIDTH];
                end else begin
                    res_lo <= partial_nxt[WIDTH-1:0];
                    // Truncated mode forces the high half to zero at load time so
                    // prod_hi stays a plain register that holds between results.
                    res_hi <= msb_q ? partial_nxt[PW-1:WIDTH] : '0;
                end
            end
        end
    end

    // Output decode: stall covers the start cycle and all of RUN, not DONE.
    always_comb begin
        stall   = start || (state == RUN);
        done    = (state == DONE);
        wr_hi   = (state == DONE) && msb_q;
        prod_lo = res_lo;
        prod_hi = res_hi;
    end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed-vector bench for mul_unit with hand-computed products.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_en;
    logic        mul_msb;
    logic        mul_acc;
    logic        mul_rst;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        stall;
    logic        done;
    logic        wr_hi;
    logic [15:0] prod_lo;
    logic [15:0] prod_hi;

    int n_vec = 0;
    int n_err = 0;

    mul_unit #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .mul_en  (mul_en),
        .mul_msb (mul_msb),
        .mul_acc (mul_acc),
        .mul_rst (mul_rst),
        .op_a    (op_a),
        .op_b    (op_b),
        .stall   (stall),
        .done    (done),
        .wr_hi   (wr_hi),
        .prod_lo (prod_lo),
        .prod_hi (prod_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle, 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decode idle: no multiply, abort line held high.
    task automatic go_idle();
        mul_en  = 1'b0;
        mul_rst = 1'b1;
        mul_msb = 1'b0;
        mul_acc = 1'b0;
    endtask

    // Cycle 0: present the instruction; stall must rise combinationally.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic msb, input logic acc, input string tag);
        op_a    = a;
        op_b    = b;
        mul_msb = msb;
        mul_acc = acc;
        mul_en  = 1'b1;
        mul_rst = 1'b0;
        #1;
        check({tag, " c0 stall"}, stall, 1);
        check({tag, " c0 done"},  done,  0);
    endtask

    // Full operation: start in the next cycle, scramble inputs during RUN,
    // then check the DONE cycle (17) and return in it.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic msb, input logic acc,
                          input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                          input string tag);
        step();
        start_op(a, b, msb, acc, tag);
        for (int c = 1; c <= 16; c++) begin
            step();
            op_a    = 16'($urandom);
            op_b    = 16'($urandom);
            mul_msb = ~msb;
            mul_acc = ~acc;
            mul_en  = 1'b0;
            mul_rst = 1'b0;
            #1;
            check($sformatf("%s c%0d stall", tag, c), stall, 1);
            check($sformatf("%s c%0d done", tag, c),  done,  0);
        end
        step();
        go_idle();
        #1;
        check({tag, " c17 done"},    done,    1);
        check({tag, " c17 stall"},   stall,   0);
        check({tag, " c17 wr_hi"},   wr_hi,   msb);
        check({tag, " c17 prod_lo"}, prod_lo, exp_lo);
        check({tag, " c17 prod_hi"}, prod_hi, exp_hi);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        go_idle();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        op_a = '0;
        op_b = '0;
        do_reset();
        #1;
        check("reset stall",   stall,   0);
        check("reset done",    done,    0);
        check("reset wr_hi",   wr_hi,   0);
        check("reset prod_lo", prod_lo, 0);
        check("reset prod_hi", prod_hi, 0);

        // Basic truncated multiply.
        run_op(16'd3, 16'd5, 1'b0, 1'b0, 16'h000F, 16'h0000, "mul16 3x5");
        step();
        #1;
        check("post-done done",    done,    0);
        check("post-done hold lo", prod_lo, 16'h000F);

        // Full-width corner: 0xFFFF * 0xFFFF = 0xFFFE0001.
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0001, 16'hFFFE, "mul32 max");

        // Truncation drops the high half: 0x1234 * 0x0100 = 0x00123400.
        run_op(16'h1234, 16'h0100, 1'b0, 1'b0, 16'h3400, 16'h0000, "mul16 trunc");

        // MAC chain from a cleared accumulator, back to back.
        do_reset();
        run_op(16'd2, 16'd3, 1'b1, 1'b1, 16'h0006, 16'h0000, "mac 2x3");
        run_op(16'd4, 16'd5, 1'b1, 1'b1, 16'h001A, 16'h0000, "mac 4x5");

        // Abort a MAC 7x9 in cycle 6: acc (0x1A) must survive untouched.
        step();
        start_op(16'd7, 16'd9, 1'b1, 1'b1, "abort");
        for (int c = 1; c <= 6; c++) begin
            step();
            mul_en  = 1'b0;
            mul_rst = (c == 6);
        end
        step();
        go_idle();
        #1;
        check("abort c7 stall", stall, 0);
        check("abort c7 done",  done,  0);
        for (int c = 8; c <= 20; c++) begin
            step();
            #1;
            check($sformatf("abort c%0d done", c), done, 0);
        end
        check("abort hold lo", prod_lo, 16'h001A);
        run_op(16'd1, 16'd1, 1'b1, 1'b1, 16'h001B, 16'h0000, "mac after abort");

        // Reset in mid-RUN clears everything including acc.
        do_reset();
        run_op(16'd4, 16'd4, 1'b1, 1'b1, 16'h0010, 16'h0000, "mac 4x4");
        step();
        start_op(16'd2, 16'd2, 1'b1, 1'b1, "rst-mid");
        for (int c = 1; c <= 4; c++) begin
            step();
            mul_en = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        go_idle();
        #1;
        check("rst-mid stall",   stall,   0);
        check("rst-mid done",    done,    0);
        check("rst-mid wr_hi",   wr_hi,   0);
        check("rst-mid prod_lo", prod_lo, 0);
        check("rst-mid prod_hi", prod_hi, 0);
        run_op(16'd1, 16'd1, 1'b1, 1'b1, 16'h0001, 16'h0000, "mac after rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
